// File: rtl/if_id_skid_reg.sv
// IF/ID boundary register: two-entry FIFO so if_ready depends only on registered state.
// Optional IF_ID_PERF_CNT_EN adds saturating stall/flush counters.
module if_id_skid_reg #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic [XLEN-1:0] if_pc,
  input  logic [XLEN-1:0] if_instr,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic            flush,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr,
  output logic            id_misaligned,
  output logic            id_valid,
`ifdef IF_ID_PERF_CNT_EN
  output logic [31:0]     stall_cycles,
  output logic [31:0]     flush_count,
`endif
  input  logic            id_ready
);

  logic [1:0]      count_q, count_d;
  logic            head_q, head_d;
  logic [XLEN-1:0] pc_q    [2];
  logic [XLEN-1:0] instr_q [2];
  logic            mis_q   [2];

  logic push, pop, tail;

  assign if_ready = (count_q != 2'd2);
  assign id_valid = (count_q != 2'd0);
  assign push     = if_valid && if_ready;
  assign pop      = id_valid && id_ready;
  // With at most one entry held when pushing, the tail is the head or the other slot.
  assign tail     = head_q ^ count_q[0];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    count_d = count_q;
    head_d  = head_q;
    if (flush) begin
      count_d = 2'd0;
      head_d  = 1'b0;
    end else begin
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      if (pop) head_d = ~head_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      count_q <= 2'd0;
      head_q  <= 1'b0;
      // NOTE: the two storage slots are reset too, so no X can ever reach id_*.
      for (int i = 0; i < 2; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
        mis_q[i]   <= 1'b0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      count_q <= count_d;
      head_q  <= head_d;
      if (push && !flush) begin
        pc_q[tail]    <= if_pc;
        instr_q[tail] <= if_instr;
        mis_q[tail]   <= (if_pc[1:0] != 2'b00);
      end
    end
  end

  assign id_pc         = id_valid ? pc_q[head_q]    : '0;
  assign id_instr      = id_valid ? instr_q[head_q] : NOP_INSTR;
  assign id_misaligned = id_valid ? mis_q[head_q]   : 1'b0;

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_q, flush_cnt_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      stall_q     <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (id_valid && !id_ready && stall_q != '1) stall_q <= stall_q + 32'd1;
      if (flush && flush_cnt_q != '1)            flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed self-checking bench for if_id_skid_reg; each task drives one scenario and
// compares {id_valid, id_pc, id_instr, id_misaligned, if_ready} to hand-computed values.
module tb_if_id_skid_reg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic [31:0] if_pc = '0, if_instr = '0;
  logic        if_valid = 1'b0, flush = 1'b0, id_ready = 1'b0;
  logic        if_ready, id_misaligned, id_valid;
  logic [31:0] id_pc, id_instr;
`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  if_id_skid_reg dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid), .if_ready(if_ready),
    .flush(flush),
    .id_pc(id_pc), .id_instr(id_instr), .id_misaligned(id_misaligned), .id_valid(id_valid),
`ifdef IF_ID_PERF_CNT_EN
    .stall_cycles(stall_cycles), .flush_count(flush_count),
`endif
    .id_ready(id_ready)
  );

  // Observed vector: {id_valid, id_pc, id_instr, id_misaligned, if_ready}
  function automatic logic [66:0] obs();
    return {id_valid, id_pc, id_instr, id_misaligned, if_ready};
  endfunction

  function automatic logic [66:0] mk(logic v, logic [31:0] pc, logic [31:0] ins,
                                     logic mis, logic rdy);
    return {v, pc, ins, mis, rdy};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(logic v, logic [31:0] pc, logic [31:0] ins);
    if_valid = v;
    if_pc    = pc;
    if_instr = ins;
  endtask

  task automatic test_reset();
    logic [66:0] exp;
    i_rstn = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    flush = 1'b0; id_ready = 1'b0;
    #12;
    exp = mk(1'b0, 32'h0, NOP, 1'b0, 1'b1);
    if (obs() !== exp) begin n_fail++; $display("FAIL reset_outputs: got %h want %h", obs(), exp); end
    n_checks++;
    @(negedge i_clk);
    i_rstn = 1'b1;
    tick();
  endtask

  task automatic test_stream();
    logic [66:0] exp;
    logic [31:0] pcs  [3] = '{32'h0, 32'h4, 32'h8};
    logic [31:0] inss [3] = '{32'h0050_0093, 32'h0040_0113, 32'h0030_0193};
    id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, pcs[i], inss[i]);
      tick();
      exp = mk(1'b1, pcs[i], inss[i], 1'b0, 1'b1);
      if (obs() !== exp) begin n_fail++; $display("FAIL stream_%0d: got %h want %h", i, obs(), exp); end
      n_checks++;
    end
    drive(1'b0, 32'h0, 32'h0);
    tick();
    exp = mk(1'b0, 32'h0, NOP, 1'b0, 1'b1);
    if (obs() !== exp) begin n_fail++; $display("FAIL stream_drain: got %h want %h", obs(), exp); end
    n_checks++;
  endtask

  task automatic test_backpressure();
    logic [66:0] exp;
    id_ready = 1'b0;
    drive(1'b1, 32'h10, 32'hAAAA_0010);
    tick();
    exp = mk(1'b1, 32'h10, 32'hAAAA_0010, 1'b0, 1'b1);
    if (obs() !== exp) begin n_fail++; $display("FAIL bp_first: got %h want %h", obs(), exp); end
    n_checks++;
    drive(1'b1, 32'h14, 32'hAAAA_0014);
    tick();
    exp = mk(1'b1, 32'h10, 32'hAAAA_0010, 1'b0, 1'b0);
    if (obs() !== exp) begin n_fail++; $display("FAIL bp_full: got %h want %h", obs(), exp); end
    n_checks++;
    drive(1'b1, 32'h18, 32'hAAAA_0018);
    tick();
    if (obs() !== exp) begin n_fail++; $display("FAIL bp_hold_0x18_rejected: got %h want %h", obs(), exp); end
    n_checks++;
    id_ready = 1'b1;
    tick();
    exp = mk(1'b1, 32'h14, 32'hAAAA_0014, 1'b0, 1'b1);
    if (obs() !== exp) begin n_fail++; $display("FAIL bp_second_out: got %h want %h", obs(), exp); end
    n_checks++;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    exp = mk(1'b0, 32'h0, NOP, 1'b0, 1'b1);
    if (obs() !== exp) begin n_fail++; $display("FAIL bp_drain: got %h want %h", obs(), exp); end
    n_checks++;
  endtask

  task automatic test_flush();
    logic [66:0] exp;
    id_ready = 1'b0;
    drive(1'b1, 32'h30, 32'hBBBB_0030); tick();
    drive(1'b1, 32'h34, 32'hBBBB_0034); tick();
    exp = mk(1'b1, 32'h30, 32'hBBBB_0030, 1'b0, 1'b0);
    if (obs() !== exp) begin n_fail++; $display("FAIL flush_prefill: got %h want %h", obs(), exp); end
    n_checks++;
    drive(1'b1, 32'h20, 32'hBBBB_0020);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    exp = mk(1'b0, 32'h0, NOP, 1'b0, 1'b1);
    if (obs() !== exp) begin n_fail++; $display("FAIL flush_empty: got %h want %h", obs(), exp); end
    n_checks++;
    id_ready = 1'b1;
    tick();
    if (obs() !== exp) begin n_fail++; $display("FAIL flush_no_0x20: got %h want %h", obs(), exp); end
    n_checks++;
    // Flush with a single entry, push and pop all in the same cycle.
    drive(1'b1, 32'h40, 32'hBBBB_0040); tick();
    drive(1'b1, 32'h44, 32'hBBBB_0044);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    if (obs() !== exp) begin n_fail++; $display("FAIL flush_push_pop: got %h want %h", obs(), exp); end
    n_checks++;
  endtask

  task automatic test_misaligned();
    logic [66:0] exp;
    id_ready = 1'b1;
    drive(1'b1, 32'h102, 32'hCCCC_0102);
    tick();
    exp = mk(1'b1, 32'h102, 32'hCCCC_0102, 1'b1, 1'b1);
    if (obs() !== exp) begin n_fail++; $display("FAIL misaligned_102: got %h want %h", obs(), exp); end
    n_checks++;
    drive(1'b1, 32'h104, 32'hCCCC_0104);
    tick();
    exp = mk(1'b1, 32'h104, 32'hCCCC_0104, 1'b0, 1'b1);
    if (obs() !== exp) begin n_fail++; $display("FAIL aligned_104: got %h want %h", obs(), exp); end
    n_checks++;
    drive(1'b0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_async_reset();
    logic [66:0] exp;
    id_ready = 1'b0;
    drive(1'b1, 32'h50, 32'hDDDD_0050); tick();
    drive(1'b1, 32'h54, 32'hDDDD_0054); tick();
    drive(1'b0, 32'h0, 32'h0);
    exp = mk(1'b1, 32'h50, 32'hDDDD_0050, 1'b0, 1'b0);
    if (obs() !== exp) begin n_fail++; $display("FAIL rst_prefill: got %h want %h", obs(), exp); end
    n_checks++;
    #2;
    i_rstn = 1'b0;
    #1;
    exp = mk(1'b0, 32'h0, NOP, 1'b0, 1'b1);
    if (obs() !== exp) begin n_fail++; $display("FAIL rst_async_midcycle: got %h want %h", obs(), exp); end
    n_checks++;
    @(negedge i_clk);
    i_rstn = 1'b1;
    id_ready = 1'b1;
    drive(1'b1, 32'h200, 32'hDDDD_0200);
    #1;
    if (obs() !== exp) begin n_fail++; $display("FAIL rst_release_empty: got %h want %h", obs(), exp); end
    n_checks++;
    tick();
    drive(1'b0, 32'h0, 32'h0);
    exp = mk(1'b1, 32'h200, 32'hDDDD_0200, 1'b0, 1'b1);
    if (obs() !== exp) begin n_fail++; $display("FAIL rst_first_push: got %h want %h", obs(), exp); end
    n_checks++;
    tick();
  endtask

`ifdef IF_ID_PERF_CNT_EN
  task automatic test_perf_counters();
    @(negedge i_clk);
    i_rstn = 1'b0;
    #1;
    if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
      n_fail++; $display("FAIL perf_reset: got %0d/%0d want 0/0", stall_cycles, flush_count);
    end
    n_checks++;
    @(negedge i_clk);
    i_rstn = 1'b1;
    id_ready = 1'b0;
    drive(1'b1, 32'h60, 32'hEEEE_0060);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    repeat (5) tick();
    id_ready = 1'b1;
    flush = 1'b1;
    repeat (2) tick();
    flush = 1'b0;
    if (stall_cycles !== 32'd5) begin n_fail++; $display("FAIL perf_stall: got %0d want 5", stall_cycles); end
    n_checks++;
    if (flush_count !== 32'd2) begin n_fail++; $display("FAIL perf_flush: got %0d want 2", flush_count); end
    n_checks++;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_misaligned();
    test_async_reset();
`ifdef IF_ID_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_skid_reg.md
Name: if_id_skid_reg

Overview:
- IF/ID pipeline boundary between the instruction fetch stage and the decode stage.
- Captures pc and instruction from fetch with a valid/ready handshake.
- Buffers up to two entries (main plus skid), so `if_ready` has no combinational path from `id_ready`.
- Supports a synchronous flush for branch/jump redirect, and presents a NOP bubble to decode when empty.

Parameters:
- XLEN, 32, width of pc and instruction.
- NOP_INSTR, 32'h0000_0013, instruction presented on `id_instr` when no valid entry is held (addi x0,x0,0).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rstn  input  1  asynchronous active-low reset.
- if_pc  input  XLEN  pc of the fetched instruction.
- if_instr  input  XLEN  fetched instruction word.
- if_valid  input  1  fetch presents a valid pc/instr pair.
- if_ready  output  1  block can accept an entry this cycle.
- flush  input  1  discard all held entries and any same-cycle push.
- id_pc  output  XLEN  pc of the head entry.
- id_instr  output  XLEN  instruction of the head entry, NOP_INSTR when empty.
- id_misaligned  output  1  head entry pc[1:0] != 0.
- id_valid  output  1  head entry valid.
- id_ready  input  1  decode consumes the head this cycle.

Behaviour:
- Storage and occupancy:
  - Two entries, each {pc, instr, misaligned}.
  - 2-bit occupancy count, 0..2; head pointer selects the oldest entry.
- Output decode:
  - `if_ready = (count != 2)`, a function of registered state only.
  - `id_valid = (count != 0)`.
  - `id_pc`, `id_instr`, `id_misaligned` driven from the head entry when `id_valid` is high.
  - When empty: `id_pc = 0`, `id_instr = NOP_INSTR`, `id_misaligned = 0`.
- Handshake:
  - push = `if_valid && if_ready`.
  - pop = `id_valid && id_ready`.
  - Entries leave in arrival order.
  - Latency: an entry pushed in cycle N is visible on `id_*` in cycle N+1.
- Occupancy transitions per clock, flush=0:
  - push only: count+1, entry written at tail.
  - pop only: count-1, head advances.
  - push and pop at count 1: count stays 1; the new entry becomes head in the next cycle.
  - push and pop at count 2: cannot occur, because `if_ready` is 0.
  - pop with count 0: cannot occur, because `id_valid` is 0.
- Misalignment: `misaligned` is computed at push as `if_pc[1:0] != 2'b00`. The entry is still passed on; decode raises the exception.
- Flush:
  - Synchronous: count goes to 0 and the head resets, regardless of push or pop in the same cycle.
  - The same-cycle push is dropped.
  - `id_valid` is 0 in the next cycle.
  - `if_ready` is 1 in the next cycle.
- Reset (asynchronous, `i_rstn` = 0):
  - count=0 and entries cleared.
  - Outputs: `id_valid=0`, `id_pc=0`, `id_instr=NOP_INSTR`, `id_misaligned=0`, `if_ready=1`.
  - Reset mid-operation discards all entries immediately.
- Storage values are held when not written; no X reaches `id_*` after reset.

Optional Feature:
- Macro: `IF_ID_PERF_CNT_EN`.
- When defined, adds two output ports:
  - `stall_cycles` (32): increments each cycle with `id_valid && !id_ready`.
  - `flush_count` (32): increments each cycle with `flush=1`.
- Both counters saturate at 32'hFFFF_FFFF and reset to 0 asynchronously.
- When undefined, neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- Reset, then `if_valid=1`, `if_pc=0x0`, `if_instr=0x00500093`, `id_ready=1`: next cycle `id_valid=1`, `id_pc=0x0`, `id_instr=0x00500093`. Streaming pc 0,4,8 gives one entry out per cycle with count held at 1.
- Backpressure with `id_ready=0`, pushing pc 0x10 then 0x14: count goes to 2 and `if_ready=0`. With `if_valid=1` still held, pc 0x18 is not accepted. Raising `id_ready` outputs 0x10 and then 0x14 in order.
- `flush=1` while count=2 and `if_valid=1` with pc 0x20: next cycle `id_valid=0`, `id_instr=0x00000013`, `if_ready=1`. pc 0x20 never appears on `id_pc`.
- Push `if_pc=0x102`: `id_misaligned=1` with `id_pc=0x102`. A following push of 0x104 gives `id_misaligned=0`.
- Assert `i_rstn=0` asynchronously mid-cycle while count=2: outputs go to their reset values before the next clock edge. After release, the first push of 0x200 appears one cycle later.
- With `IF_ID_PERF_CNT_EN` defined, 5 cycles of `id_valid=1`, `id_ready=0` plus 2 flush cycles: `stall_cycles=5`, `flush_count=2`.
